// File: rtl/traffic_sensor_conditioner.sv
// Car-sensor input stage: per-channel synchronizer and debounce FSM with registered outputs.
// Optional macro STICKY_REQUEST_EN holds each request until it is cleared by clr_a_i/clr_b_i.
//
// state     | meaning
// LOW       | debounced level 0, input agrees
// WAIT_HIGH | debounced level 0, input high, counting toward acceptance
// HIGH      | debounced level 1, input agrees
// WAIT_LOW  | debounced level 1, input low, counting toward acceptance
module traffic_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sa_raw_i,
  input  logic sb_raw_i,
  input  logic clr_a_i,
  input  logic clr_b_i,
  output logic sa_o,
  output logic sb_o,
  output logic sa_rise_o,
  output logic sb_rise_o
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_e;

  logic [1:0]             raw;
  logic [1:0]             s_sync;
  logic [SYNC_STAGES-1:0] sync_q [2];
  state_e                 state_q [2];
  state_e                 state_d [2];
  logic [CNT_W-1:0]       cnt_q [2];
  logic [CNT_W-1:0]       cnt_d [2];
  logic [1:0]             clean_q, clean_d;
  logic [1:0]             rise_q, rise_d;

  assign raw = {sb_raw_i, sa_raw_i};

  always_comb begin
    for (int c = 0; c < 2; c++) s_sync[c] = sync_q[c][SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c]  <= '0;
        state_q[c] <= LOW;
        cnt_q[c]   <= '0;
      end
      clean_q <= '0;
      rise_q  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c]  <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      clean_q <= clean_d;
      rise_q  <= rise_d;
    end
  end

  // The counter is cleared on every state change, so it never passes CNT_TC.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        LOW: begin
          if (s_sync[c]) begin
            state_d[c] = WAIT_HIGH;
            cnt_d[c]   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s_sync[c]) begin
            state_d[c] = LOW;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == CNT_TC) begin
            state_d[c] = HIGH;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s_sync[c]) begin
            state_d[c] = WAIT_LOW;
            cnt_d[c]   = '0;
          end
        end
        WAIT_LOW: begin
          if (s_sync[c]) begin
            state_d[c] = HIGH;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == CNT_TC) begin
            state_d[c] = LOW;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        default: begin
          state_d[c] = LOW;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      clean_d[c] = (state_d[c] == HIGH) || (state_d[c] == WAIT_LOW);
      rise_d[c]  = (state_q[c] == WAIT_HIGH) && (state_d[c] == HIGH);
    end
  end

  assign sa_rise_o = rise_q[0];
  assign sb_rise_o = rise_q[1];

`ifdef STICKY_REQUEST_EN
  logic [1:0] clr;
  logic [1:0] req_q, req_d;
  logic       unused_clean;

  assign clr          = {clr_b_i, clr_a_i};
  assign unused_clean = ^clean_q;

  // A clear landing in the same cycle as the rise pulse is ignored so no car is lost.
  always_comb req_d = rise_d | (req_q & ~(clr & ~rise_q));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) req_q <= '0;
    else          req_q <= req_d;
  end

  assign sa_o = req_q[0];
  assign sb_o = req_q[1];
`else
  logic unused_clr;
  assign unused_clr = clr_a_i ^ clr_b_i;

  assign sa_o = clean_q[0];
  assign sb_o = clean_q[1];
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// stimulus compared every cycle against a sample-window model of the conditioner.
module tb_traffic_sensor_conditioner;
  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sa_raw = 1'b0, sb_raw = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic sa, sb, sa_rise, sb_rise;

  int checks = 0;
  int errors = 0;

  traffic_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .sa_raw_i(sa_raw), .sb_raw_i(sb_raw),
    .clr_a_i(clr_a), .clr_b_i(clr_b),
    .sa_o(sa), .sb_o(sb), .sa_rise_o(sa_rise), .sb_rise_o(sb_rise)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: h[c][k] is the raw level sampled k edges ago; the debounce logic sees it S
  // edges late. The level flips once the last D+1 seen samples all disagree with it.
  bit h [2][S+D+1];
  bit m_clean [2];
  bit m_rise [2];
  bit m_req [2];
  logic [1:0] raw_v, clr_v;
  assign raw_v = {sb_raw, sa_raw};
  assign clr_v = {clr_b, clr_a};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        for (int j = 0; j <= S + D; j++) h[c][j] = 1'b0;
        m_clean[c] = 1'b0;
        m_rise[c]  = 1'b0;
        m_req[c]   = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit all_opp, prev_rise;
        for (int j = S + D; j > 0; j--) h[c][j] = h[c][j-1];
        h[c][0] = raw_v[c];
        all_opp = 1'b1;
        for (int j = 0; j <= D; j++) if (h[c][S+j] == m_clean[c]) all_opp = 1'b0;
        prev_rise = m_rise[c];
        m_rise[c] = 1'b0;
        if (all_opp) begin
          m_clean[c] = !m_clean[c];
          m_rise[c]  = m_clean[c];
        end
        m_req[c] = m_rise[c] | (m_req[c] & !(clr_v[c] & !prev_rise));
      end
    end
  end

  always @(negedge clk) begin
    bit es0, es1;
`ifdef STICKY_REQUEST_EN
    es0 = m_req[0];
    es1 = m_req[1];
`else
    es0 = m_clean[0];
    es1 = m_clean[1];
`endif
    chk("model_sa", sa, es0);
    chk("model_sb", sb, es1);
    chk("model_sa_rise", sa_rise, m_rise[0]);
    chk("model_sb_rise", sb_rise, m_rise[1]);
  end

  task automatic clear_reqs();
`ifdef STICKY_REQUEST_EN
    clr_a = 1'b1;
    clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
`endif
  endtask

  initial begin
    int nr, ta, tb_;
    // Reset with sa_raw high: outputs clear immediately, then a clean press follows.
    sa_raw = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sa", sa, 1'b0);
    chk("rst_sb", sb, 1'b0);
    chk("rst_sa_rise", sa_rise, 1'b0);
    chk("rst_sb_rise", sb_rise, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("press_sa", sa, i >= 7);
      chk("press_rise", sa_rise, i == 7);
    end

    // Release.
    sa_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
`ifdef STICKY_REQUEST_EN
      chk("release_sa", sa, 1'b1);
`else
      chk("release_sa", sa, i < 7);
`endif
      chk("release_rise", sa_rise, 1'b0);
    end
`ifdef STICKY_REQUEST_EN
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("sticky_clear", sa, 1'b0);
`endif

    // Bounce: high 3, low 1, then high held.
    nr = 0;
    sa_raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nr += int'(sa_rise);
    end
    sa_raw = 1'b0;
    @(negedge clk);
    nr += int'(sa_rise);
    sa_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      nr += int'(sa_rise);
      chk("bounce_sa", sa, i >= 7);
    end
    chk_int("bounce_pulses", nr, 1);

    // Independence: A and B pressed two cycles apart.
    sa_raw = 1'b0;
    repeat (8) @(negedge clk);
    clear_reqs();
    ta = -1;
    tb_ = -1;
    sa_raw = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) sb_raw = 1'b1;
      @(negedge clk);
      if (sa_rise) ta = i;
      if (sb_rise) tb_ = i;
    end
    chk_int("indep_a_edge", ta, 6);
    chk_int("indep_gap", tb_ - ta, 2);

    // Clear in the same cycle as the rise pulse: request survives.
    sa_raw = 1'b0;
    sb_raw = 1'b0;
    repeat (8) @(negedge clk);
    clear_reqs();
    sa_raw = 1'b1;
    repeat (7) @(negedge clk);
    chk("collide_rise", sa_rise, 1'b1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("collide_sa", sa, 1'b1);
`ifdef STICKY_REQUEST_EN
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("collide_later_clear", sa, 1'b0);
`endif

    // Reset mid-WAIT_HIGH: count is lost, restart from LOW.
    sa_raw = 1'b0;
    repeat (8) @(negedge clk);
    clear_reqs();
    sa_raw = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sa", sa, 1'b0);
    chk("midrst_rise", sa_rise, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nr = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      nr += int'(sa_rise);
      chk("midrst_restart_sa", sa, i >= 7);
    end
    chk_int("midrst_pulses", nr, 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) sa_raw = ~sa_raw;
      if ($urandom_range(0, 9) == 0) sb_raw = ~sb_raw;
      clr_a = ($urandom_range(0, 7) == 0);
      clr_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
